led_bank_ctrl: RTL

LED_BANK_CTRL -- requirements
Module: led_bank_ctrl

---
 rtl/led_bank_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/led_bank_ctrl.sv
// rtl/led_bank_ctrl.sv - shadowed LED bank driver with commit, clear and optional masked blink (LED_BANK_BLINK_EN)
module led_bank_ctrl #(
    parameter int LED_W = 24,
    parameter int BUS_W = 16,
    parameter int DIV_W = 22
) (
    input  logic             clk,
    input  logic             rst_in,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [1:0]       addr,
    input  logic [BUS_W-1:0] wr_data,
    output logic [BUS_W-1:0] rd_data,
    output logic [LED_W-1:0] led,
    output logic             blink_phase
);

    localparam int HI_W = LED_W - BUS_W;
    localparam logic [1:0] ADDR_LO   = 2'd0;
    localparam logic [1:0] ADDR_HI   = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_CTRL = 2'd3;

    logic [LED_W-1:0] shadow;
    logic [LED_W-1:0] active;
    logic             pending;
    logic             auto_mode;

    logic wr_lo, wr_hi, wr_ctrl, do_commit, do_clear;
    logic [BUS_W-1:0] hi_ext;
    logic [BUS_W-1:0] mask_ext;
    logic [BUS_W-1:0] ctrl_ext;
    logic [BUS_W-1:0] rd_next;
    logic [LED_W-1:0] led_next;

    assign wr_lo   = wr_en && (addr == ADDR_LO);
    assign wr_hi   = wr_en && (addr == ADDR_HI);
    assign wr_ctrl = wr_en && (addr == ADDR_CTRL);
    // Data writes use the AUTO value held before this edge; CTRL commit is unconditional.
    assign do_commit = ((wr_lo || wr_hi) && auto_mode) || (wr_ctrl && wr_data[1]);
    assign do_clear  = wr_ctrl && wr_data[2];

`ifdef LED_BANK_BLINK_EN
    localparam int NB = LED_W / 8;

    logic [NB-1:0]    mask;
    logic [DIV_W-1:0] prescaler;
    logic             phase_q;

    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            mask      <= '0;
            prescaler <= '0;
            phase_q   <= 1'b0;
        end else begin
            if (wr_en && (addr == ADDR_MASK))
                mask <= wr_data[NB-1:0];
            prescaler <= prescaler + 1'b1;
            if (&prescaler)
                phase_q <= ~phase_q;
        end
    end

    assign blink_phase = phase_q;

    always_comb begin
        mask_ext           = '0;
        mask_ext[NB-1:0]   = mask;
        led_next           = active;
        for (int b = 0; b < NB; b++) begin
            if (phase_q && mask[b])
                led_next[8*b +: 8] = 8'h00;
        end
    end
`else
    logic [DIV_W-1:0] unused_div;

    assign unused_div  = '0;
    assign blink_phase = 1'b0;
    assign mask_ext    = '0;
    assign led_next    = active;
`endif

    always_comb begin
        hi_ext            = '0;
        hi_ext[HI_W-1:0]  = shadow[LED_W-1:BUS_W];
        ctrl_ext          = '0;
        ctrl_ext[3]       = pending;
        ctrl_ext[0]       = auto_mode;
        case (addr)
            ADDR_LO:   rd_next = shadow[BUS_W-1:0];
            ADDR_HI:   rd_next = hi_ext;
            ADDR_MASK: rd_next = mask_ext;
            default:   rd_next = ctrl_ext;
        endcase
    end

    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            shadow    <= '0;
            active    <= '0;
            pending   <= 1'b0;
            auto_mode <= 1'b1;
            led       <= '0;
            rd_data   <= '0;
        end else begin
            if (wr_ctrl)
                auto_mode <= wr_data[0];
            if (do_clear) begin
                shadow  <= '0;
                active  <= '0;
                pending <= 1'b0;
            end else begin
                if (wr_lo)
                    shadow[BUS_W-1:0] <= wr_data;
                if (wr_hi)
                    shadow[LED_W-1:BUS_W] <= wr_data[HI_W-1:0];
                // Copy uses the shadow held before this edge; a new request re-arms pending.
                if (pending)
                    active <= shadow;
                pending <= do_commit;
            end
            led <= led_next;
            if (rd_en)
                rd_data <= rd_next;
        end
    end

endmodule
